// File: rtl/shift_pkg.sv
// Mode codes, FSM encoding and op classification shared by the shift
// sequencer and its down counter.
package shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_ROT  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ASR  = 3'b101;
  localparam logic [2:0] MODE_LOAD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRELOAD = 2'd1,
    ST_SHIFT   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == MODE_ROT) || (op == MODE_SHL) || (op == MODE_SHR) || (op == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_down_counter.sv
// Loadable down counter tracking the shift cycles still to issue;
// o_last flags the final one.
module shift_down_counter #(
  parameter int COUNT_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [COUNT_W-1:0] i_val,
  input  logic               i_dec,
  output logic               o_last
);

  logic [COUNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_cnt <= '0;
    else if (i_load) r_cnt <= i_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_last = (r_cnt == COUNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register: optional
// preload, then N shifts of one kind, then report the final register value.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int COUNT_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [2:0]         i_cmd_op,
  input  logic               i_cmd_preload,
  input  logic [0:3]         i_cmd_data,
  input  logic [COUNT_W-1:0] i_cmd_count,
  output logic [2:0]         o_s,
  output logic [0:3]         o_l,
  input  logic [0:3]         i_q,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [0:3]         o_result
);

  state_t     r_state, w_next;
  logic [2:0] r_op;
  logic [0:3] r_data;
  logic       r_nz;
  logic [2:0] r_s;
  logic [0:3] r_l;
  logic       r_done, r_err, r_busy, r_ready;
  logic [0:3] r_result;

  logic       w_idle, w_accept, w_last, w_legal, w_nz, w_go_shift;
  logic [2:0] w_op;
  logic [0:3] w_data;

  // In IDLE the command fields are not captured yet, so decisions look at the inputs.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_accept   = w_idle && i_cmd_valid;
  assign w_op       = w_idle ? i_cmd_op : r_op;
  assign w_data     = w_idle ? i_cmd_data : r_data;
  assign w_nz       = w_idle ? (i_cmd_count != '0) : r_nz;
  assign w_legal    = is_shift_op(w_op);
  assign w_go_shift = w_nz && w_legal;

  shift_down_counter #(.COUNT_W(COUNT_W)) u_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_accept),
    .i_val  (i_cmd_count),
    .i_dec  (r_state == ST_SHIFT),
    .o_last (w_last)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_preload)   w_next = ST_PRELOAD;
          else if (w_go_shift) w_next = ST_SHIFT;
          else                 w_next = ST_DONE;
        end
      end
      ST_PRELOAD: w_next = w_go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT:   w_next = w_last ? ST_DONE : ST_SHIFT;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_op     <= MODE_HOLD;
      r_data   <= '0;
      r_nz     <= 1'b0;
      r_s      <= MODE_HOLD;
      r_l      <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= i_cmd_op;
        r_data <= i_cmd_data;
        r_nz   <= (i_cmd_count != '0);
      end
      case (w_next)
        ST_PRELOAD: r_s <= MODE_LOAD;
        ST_SHIFT:   r_s <= w_op;
        default:    r_s <= MODE_HOLD;
      endcase
      r_l     <= (w_next == ST_PRELOAD) ? w_data : 4'b0000;
      r_done  <= (w_next == ST_DONE);
      r_err   <= (w_next == ST_DONE) && !w_legal;
      r_busy  <= (w_next != ST_IDLE);
      r_ready <= (w_next == ST_IDLE);
      // Q reflects the last shift only once DONE is reached.
      if (r_state == ST_DONE) r_result <= i_q;
    end
  end

  assign o_s         = r_s;
  assign o_l         = r_l;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_busy      = r_busy;
  assign o_cmd_ready = r_ready;
  assign o_result    = r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: directed commands push expectations, a monitor checks
// each done pulse against a behavioural universal shift register.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic       cmd_preload = 1'b0;
  logic [0:3] cmd_data = 4'b0000;
  logic [2:0] cmd_count = 3'd0;
  logic [2:0] s;
  logic [0:3] l;
  logic [0:3] q;
  logic       busy, done, err;
  logic [0:3] result;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [0:3] res;
    logic       err;
    int         cyc;
    int         busy;
  } exp_t;

  exp_t       sbq[$];
  bit         pend = 1'b0;
  logic [0:3] pend_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural universal shift register driven by the DUT.
  always @(posedge clk) begin
    case (s)
      3'b001: q <= {q[3], q[0:2]};
      3'b010: q <= {q[1:3], 1'b0};
      3'b011: q <= {1'b0, q[0:2]};
      3'b101: q <= {q[0], q[0:2]};
      3'b111: q <= l;
      default: q <= q;
    endcase
  end

  shift_sequencer #(.COUNT_W(3)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_preload (cmd_preload),
    .i_cmd_data    (cmd_data),
    .i_cmd_count   (cmd_count),
    .o_s           (s),
    .o_l           (l),
    .i_q           (q),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_result      (result)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts busy cycles, checks done/err/latency, then result one cycle later.
  initial begin
    int bcnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        bcnt = 0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("result", int'(result), int'(pend_res));
          pend = 1'b0;
        end
        if (busy) bcnt++;
        if (done) begin
          if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("err", int'(err), int'(e.err));
            chk("busy_cycles", bcnt, e.busy);
            pend_res = e.res;
            pend = 1'b1;
          end
          bcnt = 0;
        end
      end
    end
  end

  // Presents a command, returns #1 after its accept edge.
  task automatic send(input logic [2:0] op, input logic pre, input logic [0:3] data,
                      input logic [2:0] cnt, input logic [0:3] res, input logic e,
                      input int n, input bit expect_done, output int acc);
    int p;
    bit ok;
    p = pre ? 1 : 0;
    ok = 1'b0;
    acc = 0;
    @(negedge clk);
    cmd_op = op; cmd_preload = pre; cmd_data = data; cmd_count = cnt; cmd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("ready_timeout", 0, 1);
    acc = cyc + 1;
    if (expect_done) sbq.push_back('{res: res, err: e, cyc: acc + p + n, busy: p + n + 1});
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !pend) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  initial begin
    int acc;
    logic [2:0] sx[4];
    sx[0] = 3'b111; sx[1] = 3'b010; sx[2] = 3'b010; sx[3] = 3'b000;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s", int'(s), 0);
    chk("rst_l", int'(l), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(cmd_ready), 1);

    // SHL x2 after preload, with S/L sequence
    send(3'b010, 1'b1, 4'b1011, 3'd2, 4'b1100, 1'b0, 2, 1'b1, acc);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("shl_s%0d", i), int'(s), int'(sx[i]));
      if (i == 0) chk("shl_l_preload", int'(l), int'(4'b1011));
      if (i == 1) begin
        chk("shl_l_shift", int'(l), 0);
        chk("shl_ready_busy", int'(cmd_ready), 0);
      end
    end
    wait_idle();

    send(3'b101, 1'b1, 4'b1011, 3'd2, 4'b1110, 1'b0, 2, 1'b1, acc); wait_idle();
    send(3'b011, 1'b1, 4'b1011, 3'd1, 4'b0101, 1'b0, 1, 1'b1, acc); wait_idle();
    send(3'b001, 1'b1, 4'b1011, 3'd4, 4'b1011, 1'b0, 4, 1'b1, acc); wait_idle();
    // Illegal op with preload: one LOAD, no shifts
    send(3'b110, 1'b1, 4'b0110, 3'd5, 4'b0110, 1'b1, 0, 1'b1, acc); wait_idle();
    // count 0 legal op, no preload
    send(3'b010, 1'b0, 4'b1111, 3'd0, 4'b0110, 1'b0, 0, 1'b1, acc); wait_idle();
    // Illegal HOLD op, no preload
    send(3'b000, 1'b0, 4'b1111, 3'd3, 4'b0110, 1'b1, 0, 1'b1, acc); wait_idle();
    // Maximum count: ROT x7 == ROT x3
    send(3'b001, 1'b1, 4'b1000, 3'd7, 4'b0001, 1'b0, 7, 1'b1, acc); wait_idle();

    // Reset during the second SHIFT cycle aborts with no done
    send(3'b010, 1'b0, 4'b0000, 3'd7, 4'b0000, 1'b0, 7, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_s", int'(s), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_l", int'(l), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_result", int'(result), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", int'(done), 0);

    // cmd_valid held while busy: second command accepted only after IDLE
    send(3'b010, 1'b1, 4'b1011, 3'd1, 4'b0110, 1'b0, 1, 1'b1, acc);
    cmd_op = 3'b001; cmd_preload = 1'b0; cmd_data = 4'b1111; cmd_count = 3'd2;
    cmd_valid = 1'b1;
    sbq.push_back('{res: 4'b1001, err: 1'b0, cyc: acc + 6, busy: 3});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cyc == acc + 4) break;
    end
    cmd_valid = 1'b0;
    wait_idle();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
